// File: rtl/jkff_bank_ctrl.sv
// Command controller for a bank of WIDTH JK flip-flops.
// An accepted command applies cmd_len+1 JK steps (hold/clear/set/toggle/count) unless aborted.
module jkff_bank_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [3:0]       cmd_len,
    input  logic             abort,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             aborted
);
    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_UP     = 3'd4;
    localparam logic [2:0] OP_DOWN   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_q;
    logic [3:0]       r_cnt;
    logic             r_aborted;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_accept;

    // Bit i is the AND of v[i-1:0]; bit 0 is always 1 (ripple carry/borrow enable).
    function automatic logic [WIDTH-1:0] f_carry(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] res;
        logic             acc;
        acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = acc;
            acc    = acc & v[i];
        end
        return res;
    endfunction

    assign w_accept = (r_state == S_IDLE) && cmd_valid;
    assign w_up     = f_carry(r_q);
    assign w_dn     = f_carry(~r_q);

    // Carry chains see the whole bank; the mask only gates which bits are driven.
    always_comb begin
        w_j = '0;
        w_k = '0;
        if (r_state == S_RUN && !abort) begin
            case (r_op)
                OP_HOLD: ;
                OP_CLEAR: w_k = r_mask;
                OP_SET:   w_j = r_mask;
                OP_TOGGLE: begin
                    w_j = r_mask;
                    w_k = r_mask;
                end
                OP_UP: begin
                    w_j = w_up & r_mask;
                    w_k = w_up & r_mask;
                end
                OP_DOWN: begin
                    w_j = w_dn & r_mask;
                    w_k = w_dn & r_mask;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_state_nxt = S_RUN;
            S_RUN:   if (abort || r_cnt == 4'd0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q       <= '0;
            r_op      <= OP_HOLD;
            r_mask    <= '0;
            r_cnt     <= 4'd0;
            r_aborted <= 1'b0;
        end else begin
            r_q <= (w_j & ~r_q) | (~w_k & r_q);
            if (w_accept) begin
                r_op      <= cmd_op;
                r_mask    <= cmd_mask;
                r_cnt     <= cmd_len;
                r_aborted <= 1'b0;
            end else if (r_state == S_RUN) begin
                if (abort) begin
                    r_aborted <= 1'b1;
                end else if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign jk_j      = w_j;
    assign jk_k      = w_k;
    assign q         = r_q;
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign aborted   = r_aborted;

endmodule

// File: tb/tb_jkff_bank_ctrl.sv
// Bench for jkff_bank_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a command-level reference model.
module tb_jkff_bank_ctrl;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_mask;
    logic [3:0]   cmd_len;
    logic         abort;
    logic [W-1:0] jk_j;
    logic [W-1:0] jk_k;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         aborted;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: phase 0 idle, 1 running, 2 done.
    int           m_phase = 0;
    int           m_left  = 0;
    logic [2:0]   m_op    = 3'd0;
    logic [W-1:0] m_mask  = '0;
    logic [W-1:0] m_q     = '0;
    logic         m_ab    = 1'b0;

    jkff_bank_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_len(cmd_len), .abort(abort),
        .jk_j(jk_j), .jk_k(jk_k), .q(q), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bits that flip in one step: counting uses plain +1/-1 arithmetic on the bank value.
    function automatic logic [W-1:0] m_flip(input logic [2:0] op, input logic [W-1:0] mk,
                                            input logic [W-1:0] qq);
        logic [W-1:0] inc;
        logic [W-1:0] dec;
        inc = qq + 1'b1;
        dec = qq - 1'b1;
        case (op)
            3'd3:    return mk;
            3'd4:    return (inc ^ qq) & mk;
            3'd5:    return (dec ^ qq) & mk;
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] m_next(input logic [2:0] op, input logic [W-1:0] mk,
                                            input logic [W-1:0] qq);
        case (op)
            3'd1:    return qq & ~mk;
            3'd2:    return qq | mk;
            default: return qq ^ m_flip(op, mk, qq);
        endcase
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_phase <= 0; m_q <= '0; m_ab <= 1'b0; m_left <= 0; m_op <= 3'd0; m_mask <= '0;
        end else begin
            case (m_phase)
                0: if (cmd_valid) begin
                    m_phase <= 1; m_op <= cmd_op; m_mask <= cmd_mask;
                    m_left <= int'(cmd_len); m_ab <= 1'b0;
                end
                1: if (abort) begin
                    m_ab <= 1'b1; m_phase <= 2;
                end else begin
                    m_q <= m_next(m_op, m_mask, m_q);
                    if (m_left == 0) m_phase <= 2;
                    else m_left <= m_left - 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge CLK) begin
        logic [W-1:0] ej;
        logic [W-1:0] ek;
        if (chk_en) begin
            ej = '0;
            ek = '0;
            if (m_phase == 1 && !abort) begin
                ej = (m_op == 3'd2) ? m_mask : m_flip(m_op, m_mask, m_q);
                ek = (m_op == 3'd1) ? m_mask : m_flip(m_op, m_mask, m_q);
            end
            chk("cyc_ready", cmd_ready, m_phase == 0);
            chk("cyc_busy", busy, m_phase == 1);
            chk("cyc_done", done, m_phase == 2);
            chk("cyc_q", q, m_q);
            chk("cyc_jk_j", jk_j, ej);
            chk("cyc_jk_k", jk_k, ek);
            if (m_phase == 2) chk("cyc_aborted", aborted, m_ab);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 64) begin
            cyc();
            n++;
        end
        chk("ready_wait", cmd_ready, 1);
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] mk, input logic [3:0] ln);
        wait_ready();
        cmd_valid = 1'b1; cmd_op = op; cmd_mask = mk; cmd_len = ln;
        cyc();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] seq [3];
        int nb;
        RST = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_mask = '0; cmd_len = 4'd0; abort = 1'b0;
        cyc(); cyc();
        RST = 1'b0;
        chk_en = 1'b1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", q, 0);
        chk("rst_jk", {jk_j, jk_k}, 0);

        // SET all bits, single step
        send(3'd2, 4'hF, 4'd0);
        chk("set_busy", busy, 1);
        cyc();
        chk("set_q", q, 4'hF);
        chk("set_done", done, 1);
        chk("set_aborted", aborted, 0);
        cyc();
        chk("set_ready", cmd_ready, 1);

        // COUNT_UP through wrap-around from 1110
        send(3'd1, 4'h1, 4'd0);
        send(3'd4, 4'hF, 4'd2);
        seq = '{4'hF, 4'h0, 4'h1};
        nb = int'(busy);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("up_q", q, seq[i]);
            nb += int'(busy);
        end
        chk("up_busy_cycles", nb, 3);
        chk("up_done", done, 1);
        cyc();
        chk("up_done_pulse", done, 0);

        // COUNT_DOWN wrap, then TOGGLE back
        send(3'd1, 4'hF, 4'd0);
        send(3'd5, 4'hF, 4'd0);
        cyc();
        chk("down_q", q, 4'hF);
        send(3'd3, 4'h5, 4'd1);
        cyc();
        chk("tog_q1", q, 4'hA);
        cyc();
        chk("tog_q2", q, 4'hF);

        // Abort in the 4th RUN cycle of a long count
        send(3'd1, 4'hF, 4'd0);
        send(3'd4, 4'hF, 4'd15);
        cyc(); cyc(); cyc();
        abort = 1'b1;
        #1;
        chk("abort_q", q, 4'h3);
        chk("abort_jk", {jk_j, jk_k}, 0);
        cyc();
        abort = 1'b0;
        chk("abort_done", done, 1);
        chk("abort_flag", aborted, 1);
        chk("abort_q_after", q, 4'h3);

        // Reset in the 3rd RUN cycle of a CLEAR
        send(3'd2, 4'hF, 4'd0);
        send(3'd1, 4'hF, 4'd7);
        cyc(); cyc();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        chk("rstmid_q", q, 0);
        chk("rstmid_ready", cmd_ready, 1);
        chk("rstmid_done", done, 0);
        cyc();
        chk("rstmid_done2", done, 0);

        // cmd_valid held high with changing op while busy
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_mask = 4'hF; cmd_len = 4'd2;
        cyc();
        for (int i = 0; i < 3; i++) begin
            cmd_op = 3'($urandom_range(0, 7));
            cmd_mask = W'($urandom_range(0, 15));
            cmd_len = 4'($urandom_range(0, 15));
            cyc();
        end
        chk("hold_q", q, 4'hF);
        chk("hold_done", done, 1);
        cyc();
        chk("hold_ready", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 3'($urandom_range(0, 7));
            cmd_mask = W'($urandom_range(0, 15));
            cmd_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            abort = ($urandom_range(0, 11) == 0);
            RST = ($urandom_range(0, 299) == 0);
            cyc();
        end
        cmd_valid = 1'b0; abort = 1'b0; RST = 1'b0;
        for (int i = 0; i < 20; i++) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jkff_bank_ctrl.md
JKFF_BANK_CTRL -- requirements
Module: jkff_bank_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, number of JK flip-flop bits in the controlled bank (2..8).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  controller accepts a command; equals 1 exactly in IDLE.
REQ-006 cmd_op  input  3  operation: 0 HOLD, 1 CLEAR, 2 SET, 3 TOGGLE, 4 COUNT_UP, 5 COUNT_DOWN, 6-7 reserved (treated as HOLD).
REQ-007 cmd_mask  input  WIDTH  per-bit enable; masked-off bits receive J=K=0.
REQ-008 cmd_len  input  4  step count minus one (1..16 steps).
REQ-009 abort  input  1  terminate a running command.
REQ-010 jk_j, jk_k  output  WIDTH each  J/K drive applied to the bank in the current cycle.
REQ-011 q  output  WIDTH  bank state (registered JK flip-flop outputs).
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  one-cycle pulse in DONE.
REQ-014 aborted  output  1  valid with done; 1 when the command ended by abort.

Function
REQ-015 The block SHALL hold one FSM with states IDLE, RUN, DONE, plus registers op, mask, remaining-step counter, aborted flag.
REQ-016 Accept: cmd_valid=1 and cmd_ready=1 at an edge SHALL latch op/mask/len and enter RUN; counter loaded with cmd_len.
REQ-017 Command inputs SHALL be ignored outside IDLE.
REQ-018 In RUN, jk_j/jk_k SHALL be driven combinationally from latched op, mask and q; each bit i updates at the edge per JK rule: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-019 Per-op drive for enabled bits: HOLD J=0,K=0; CLEAR J=0,K=1; SET J=1,K=0; TOGGLE J=1,K=1.
REQ-020 COUNT_UP: J_i=K_i=AND of q[i-1:0] (bit 0 = 1), carry chain over all bits regardless of mask.
REQ-021 COUNT_DOWN: J_i=K_i=AND of ~q[i-1:0] (bit 0 = 1).
REQ-022 Wrap-around: all-ones COUNT_UP SHALL yield all-zeros; all-zeros COUNT_DOWN SHALL yield all-ones (mask all ones).
REQ-023 Outside RUN, jk_j=jk_k=0 and q SHALL hold.
REQ-024 RUN SHALL last exactly cmd_len+1 cycles (one step per cycle); counter decrements each step; at counter 0 the step is applied and state goes to DONE.
REQ-025 DONE SHALL last exactly one cycle (done=1, cmd_ready=0), then IDLE.
REQ-026 Latency: accept at edge t0 -> q updates at edges t1..t(len+1) -> done high in the cycle after t(len+1) -> cmd_ready high one cycle later.
REQ-027 abort=1 in RUN SHALL force jk_j=jk_k=0 that cycle (no step applied), set aborted, enter DONE; abort in IDLE/DONE SHALL be ignored.
REQ-028 abort coinciding with the final step SHALL suppress that step and report aborted=1.
REQ-029 aborted SHALL clear on the next accepted command.
REQ-030 mask=0 SHALL run the full step count with q unchanged and done pulsed normally.

Reset
REQ-031 RST=1 at an edge SHALL set q=0, state IDLE, counter=0, latched op HOLD, mask 0, aborted=0.
REQ-032 After reset: cmd_ready=1, busy=0, done=0, jk_j=jk_k=0.
REQ-033 RST SHALL override abort, command acceptance and any RUN step in the same cycle; reset mid-command SHALL produce no done pulse.

Verification
REQ-034 Reset, then SET mask=1111 len=0 -> q=1111 after t1, done at cycle after t1, aborted=0.
REQ-035 From q=1110, COUNT_UP mask=1111 len=2 -> q sequence 1111, 0000, 0001; busy 3 cycles; one done pulse.
REQ-036 From q=0000, COUNT_DOWN len=0 -> q=1111; TOGGLE mask=0101 len=1 -> q back to 1111 after 2 steps.
REQ-037 COUNT_UP len=15 from 0000, abort asserted in 4th RUN cycle -> q=0011, jk_j/jk_k=0 that cycle, done=1 with aborted=1.
REQ-038 CLEAR len=7 from 1111, RST asserted in 3rd RUN cycle -> q=0000, IDLE, no done pulse, cmd_ready=1 next cycle.
REQ-039 cmd_valid held high with changing op during RUN/DONE -> ignored; next command accepted only when cmd_ready=1.
